// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One radix-2 step per cycle on magnitudes, sign fix-up in a final cycle.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  // state | meaning
  // IDLE  | waiting for start, MTHI/MTLO allowed
  // CALC  | one shift-add / shift-subtract step per cycle
  // FIX   | sign correction, HI/LO written
  // DONE  | result valid, one-cycle done pulse, accepts next start
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, nextState;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   aHold;
  logic               isDiv, negRes, negRem, divZero;

  logic               accepting, isSigned;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext, divNext, prodFix;
  logic [WIDTH:0]     divShift;
  logic [WIDTH+1:0]   divDiff;
  logic [WIDTH-1:0]   quo, rem;

  assign accepting = (state == IDLE) || (state == DONE);
  assign isSigned  = ~op[0];
  assign aMag      = (isSigned && a[WIDTH-1]) ? -a : a;
  assign bMag      = (isSigned && b[WIDTH-1]) ? -b : b;

  // Multiply: upper half accumulates, multiplier shifts out of the low end.
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half the dividend/quotient.
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divDiff  = {1'b0, divShift} - {2'b00, opnd};
  assign divNext  = divDiff[WIDTH+1] ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prodFix = negRes ? -acc : acc;
  assign quo     = acc[WIDTH-1:0];
  assign rem     = acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = CALC;
      CALC:    if (cnt == LAST) nextState = FIX;
      FIX:     nextState = DONE;
      DONE:    nextState = start ? CALC : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      aHold   <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (accepting && start) begin
      cnt     <= '0;
      isDiv   <= op[1];
      negRes  <= isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
      negRem  <= isSigned && a[WIDTH-1];
      divZero <= op[1] && (b == '0);
      aHold   <= a;
      if (op[1]) begin
        acc  <= {{WIDTH{1'b0}}, aMag};
        opnd <= bMag;
      end else begin
        acc  <= {{WIDTH{1'b0}}, bMag};
        opnd <= aMag;
      end
    end else if (accepting) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= isDiv ? divNext : mulNext;
    end else if (state == FIX) begin
      if (!isDiv) begin
        {hi, lo} <= prodFix;
      end else if (divZero) begin
        hi <= aHold;
        lo <= '1;
      end else begin
        lo <= negRes ? -quo : quo;
        hi <= negRem ? -rem : rem;
      end
    end
  end

endmodule
